// File: rtl/gpu_launch_pkg.sv
// gpu_launch_pkg: shared types for the kernel launch front end
package gpu_launch_pkg;
  localparam int KERNEL_ID_BITS = 4;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, COMPLETE} launch_state_t;
  typedef struct packed {
    logic [KERNEL_ID_BITS-1:0] id;
    logic [7:0]                thread_count;
  } launch_entry_t;
endpackage

// File: rtl/launch_fifo.sv
// launch_fifo: synchronous FIFO of launch entries; the head is readable without a pop
module launch_fifo
  import gpu_launch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  launch_entry_t wdata,
  output launch_entry_t rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  localparam int PW = $clog2(DEPTH);
  launch_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  assign rdata = mem[rd_ptr];
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end
endmodule

// File: rtl/kernel_launch_queue.sv
// kernel_launch_queue: buffers host kernel launches and sequences them through the dispatch unit
module kernel_launch_queue
  import gpu_launch_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int LW = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      host_valid,
  output logic                      host_ready,
  input  logic [7:0]                host_thread_count,
  output logic [KERNEL_ID_BITS-1:0] host_id,
  input  logic                      abort,
  output logic                      dispatch_reset,
  output logic                      dispatch_start,
  output logic [7:0]                dispatch_thread_count,
  input  logic                      dispatch_done,
  output logic                      kernel_done,
  output logic [KERNEL_ID_BITS-1:0] done_id,
  output logic                      done_aborted,
  output logic [LW-1:0]             queue_level,
  output logic                      busy
);
  launch_state_t state, state_n;
  launch_entry_t cur, head, wdata;
  logic push, pop, full, empty, aborted;
  assign host_ready = !reset && !full;
  assign push = host_valid && host_ready;
  assign pop = state == IDLE && !empty;
  assign wdata = '{id: host_id, thread_count: host_thread_count};
  launch_fifo #(.DEPTH(QUEUE_DEPTH), .LW(LW)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .wdata(wdata),
    .rdata(head), .full(full), .empty(empty), .level(queue_level)
  );
  // zero-thread kernels skip dispatch entirely; done beats abort in RUN
  always_comb
    state_n = state == IDLE ? (empty ? IDLE : (head.thread_count != '0 ? LOAD : COMPLETE)) :
              state == LOAD ? RUN :
              state == RUN  ? ((dispatch_done || abort) ? COMPLETE : RUN) : IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cur <= '0;
      aborted <= 1'b0;
      host_id <= '0;
    end else begin
      state <= state_n;
      if (pop) cur <= head;
      aborted <= state == RUN ? abort && !dispatch_done : (pop ? 1'b0 : aborted);
      if (push) host_id <= host_id + 1'b1;
    end
  end
  assign dispatch_reset = state != RUN;
  assign dispatch_start = state == RUN;
  assign dispatch_thread_count = cur.thread_count;
  assign kernel_done = state == COMPLETE;
  assign done_id = cur.id;
  assign done_aborted = aborted;
  assign busy = state != IDLE || queue_level != '0;
endmodule
